// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: opcodes, funct codes, ALU codes, select codes and FSM states for the multicycle MIPS control.
package multicycle_control_pkg;
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECUTE, S_ALUWB,
        S_BEQ, S_BNE, S_ADDI_EX, S_ADDI_WB, S_JUMP, S_JAL, S_HALT
    } state_t;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_4    = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM4 = 2'b11;
    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;
endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// multicycle_control_alu_decoder: R-type funct to ALU control, flagging encodings the core cannot execute.
module multicycle_control_alu_decoder
    import multicycle_control_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       legal
);
    always_comb begin
        legal = funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
        alu_control = funct == F_SUB ? ALU_SUB :
                      funct == F_AND ? ALU_AND :
                      funct == F_OR  ? ALU_OR  :
                      funct == F_SLT ? ALU_SLT : ALU_ADD;
    end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: sequencing FSM for the multicycle MIPS core, Moore-decoded selects and strobes.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               iord,
    output logic               mem_write,
    output logic               ir_write,
    output logic               pc_en,
    output logic [1:0]         pc_src,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_control,
    output logic               reg_write,
    output logic [1:0]         reg_dst,
    output logic               memto_reg,
    output logic               link,
    output logic               retire,
    output logic               halted,
    output logic [STATE_W-1:0] state
);
    state_t state_q, state_d, decode_next;
    logic [2:0] funct_alu;
    logic funct_legal;

    multicycle_control_alu_decoder u_alu_dec (
        .funct(funct),
        .alu_control(funct_alu),
        .legal(funct_legal)
    );

    always_comb begin
        case (op)
            OP_LW, OP_SW: decode_next = S_MEMADR;
            OP_R:         decode_next = funct_legal ? S_EXECUTE : S_HALT;
            OP_BEQ:       decode_next = S_BEQ;
            OP_BNE:       decode_next = S_BNE;
            OP_ADDI:      decode_next = S_ADDI_EX;
            OP_J:         decode_next = S_JUMP;
            OP_JAL:       decode_next = S_JAL;
            default:      decode_next = S_HALT;
        endcase
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:   state_d = decode_next;
            S_MEMADR:   state_d = op == OP_SW ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ADDI_EX:  state_d = S_ADDI_WB;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        mem_req     = 1'b0;
        iord        = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        pc_en       = 1'b0;
        pc_src      = PC_ALU;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_B;
        alu_control = ALU_ADD;
        reg_write   = 1'b0;
        reg_dst     = DST_RT;
        memto_reg   = 1'b0;
        link        = 1'b0;
        retire      = 1'b0;
        halted      = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_4;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
            end
            S_DECODE: alu_src_b = SRCB_IMM4;
            S_MEMADR, S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                memto_reg = 1'b1;
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                iord      = 1'b1;
                mem_write = 1'b1;
                retire    = mem_ready;
            end
            S_EXECUTE: begin
                alu_src_a   = 1'b1;
                alu_control = funct_alu;
            end
            S_ALUWB: begin
                reg_dst   = DST_RD;
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_BEQ, S_BNE: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
                pc_src      = PC_ALUOUT;
                pc_en       = zero ^ (state_q == S_BNE);
                retire      = 1'b1;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_JUMP: begin
                pc_src = PC_JUMP;
                pc_en  = 1'b1;
                retire = 1'b1;
            end
            // $31 takes the live PC+4 of the already-incremented PC, i.e. PC+8 of the jal
            S_JAL: begin
                pc_src    = PC_JUMP;
                pc_en     = 1'b1;
                alu_src_b = SRCB_4;
                link      = 1'b1;
                reg_dst   = DST_RA;
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
        if (reset) begin
            mem_req   = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            pc_en     = 1'b0;
            reg_write = 1'b0;
            retire    = 1'b0;
        end
    end

    assign state = STATE_W'(state_q);
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: randomized instruction stream against a per-cycle output table and a retire-latency scoreboard.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    typedef struct packed {
        logic [3:0] st;
        logic       mem_req, iord, mem_write, ir_write, pc_en;
        logic [1:0] pc_src;
        logic       a;
        logic [1:0] b;
        logic [2:0] alu;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic       memto, link, retire, halted;
    } vec_t;

    logic clk = 1'b0, reset = 1'b1, zero = 1'b0, mem_ready = 1'b0;
    logic [5:0] op = '0, funct = '0;
    logic mem_req, iord, mem_write, ir_write, pc_en, alu_src_a, reg_write, memto_reg, link, retire, halted;
    logic [1:0] pc_src, alu_src_b, reg_dst;
    logic [2:0] alu_control;
    logic [3:0] state;

    vec_t exp_q[$];
    int lat_q[$];
    int n_cmp = 0, n_err = 0, cyc_cnt = 0;
    logic [5:0] ops [8];
    logic [5:0] functs [5];
    logic [5:0] o;

    always #5 clk = ~clk;

    multicycle_control #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .iord(iord), .mem_write(mem_write), .ir_write(ir_write), .pc_en(pc_en),
        .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
        .reg_write(reg_write), .reg_dst(reg_dst), .memto_reg(memto_reg), .link(link),
        .retire(retire), .halted(halted), .state(state)
    );

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [2:0] fmap(logic [5:0] f);
        return f == F_SUB ? ALU_SUB : f == F_AND ? ALU_AND : f == F_OR ? ALU_OR :
               f == F_SLT ? ALU_SLT : ALU_ADD;
    endfunction

    function automatic int base_lat(logic [5:0] op_i);
        return op_i == OP_LW ? 5 : (op_i == OP_SW || op_i == OP_R || op_i == OP_ADDI) ? 4 : 3;
    endfunction

    // Output table: what each state must show, given the live inputs of that cycle.
    function automatic vec_t ev(state_t s, logic rdy, logic z, logic rst, logic [5:0] f);
        vec_t v = '0;
        v.st = s;
        v.alu = ALU_ADD;
        case (s)
            S_FETCH:    begin v.mem_req = 1; v.b = SRCB_4; v.ir_write = rdy; v.pc_en = rdy; end
            S_DECODE:   v.b = SRCB_IMM4;
            S_MEMADR:   begin v.a = 1; v.b = SRCB_IMM; end
            S_MEMREAD:  begin v.mem_req = 1; v.iord = 1; end
            S_MEMWB:    begin v.memto = 1; v.reg_write = 1; v.retire = 1; end
            S_MEMWRITE: begin v.mem_req = 1; v.iord = 1; v.mem_write = 1; v.retire = rdy; end
            S_EXECUTE:  begin v.a = 1; v.alu = fmap(f); end
            S_ALUWB:    begin v.reg_dst = DST_RD; v.reg_write = 1; v.retire = 1; end
            S_BEQ:      begin v.a = 1; v.alu = ALU_SUB; v.pc_src = PC_ALUOUT; v.pc_en = z; v.retire = 1; end
            S_BNE:      begin v.a = 1; v.alu = ALU_SUB; v.pc_src = PC_ALUOUT; v.pc_en = !z; v.retire = 1; end
            S_ADDI_EX:  begin v.a = 1; v.b = SRCB_IMM; end
            S_ADDI_WB:  begin v.reg_write = 1; v.retire = 1; end
            S_JUMP:     begin v.pc_src = PC_JUMP; v.pc_en = 1; v.retire = 1; end
            S_JAL:      begin v.pc_src = PC_JUMP; v.pc_en = 1; v.b = SRCB_4; v.link = 1;
                              v.reg_dst = DST_RA; v.reg_write = 1; v.retire = 1; end
            S_HALT:     v.halted = 1;
            default:    ;
        endcase
        if (rst) begin
            v.mem_req = 0; v.mem_write = 0; v.ir_write = 0; v.pc_en = 0; v.reg_write = 0; v.retire = 0;
        end
        return v;
    endfunction

    task automatic step(input state_t s, input logic rdy, input logic rst, input logic z);
        reset = rst;
        zero = z;
        mem_ready = rdy;
        exp_q.push_back(ev(s, rdy, z, rst, funct));
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] op_i, input logic [5:0] f, input int wf, input int wm, input logic zb);
        bit mem_op = (op_i == OP_LW || op_i == OP_SW);
        state_t ms = op_i == OP_LW ? S_MEMREAD : S_MEMWRITE;
        op = op_i;
        funct = f;
        lat_q.push_back(base_lat(op_i) + wf + (mem_op ? wm : 0));
        repeat (wf) step(S_FETCH, 1'b0, 1'b0, rb());
        step(S_FETCH, 1'b1, 1'b0, rb());
        step(S_DECODE, rb(), 1'b0, rb());
        if (mem_op) begin
            step(S_MEMADR, rb(), 1'b0, rb());
            repeat (wm) step(ms, 1'b0, 1'b0, rb());
            step(ms, 1'b1, 1'b0, rb());
            if (op_i == OP_LW) step(S_MEMWB, rb(), 1'b0, rb());
        end else if (op_i == OP_R) begin
            step(S_EXECUTE, rb(), 1'b0, rb());
            step(S_ALUWB, rb(), 1'b0, rb());
        end else if (op_i == OP_ADDI) begin
            step(S_ADDI_EX, rb(), 1'b0, rb());
            step(S_ADDI_WB, rb(), 1'b0, rb());
        end else if (op_i == OP_BEQ) step(S_BEQ, rb(), 1'b0, zb);
        else if (op_i == OP_BNE) step(S_BNE, rb(), 1'b0, zb);
        else if (op_i == OP_J) step(S_JUMP, rb(), 1'b0, rb());
        else step(S_JAL, rb(), 1'b0, rb());
    endtask

    task automatic halt_seq(input logic [5:0] op_i, input logic [5:0] f);
        op = op_i;
        funct = f;
        step(S_FETCH, 1'b1, 1'b0, rb());
        step(S_DECODE, rb(), 1'b0, rb());
        repeat (10) step(S_HALT, rb(), 1'b0, rb());
        step(S_HALT, rb(), 1'b1, rb());
    endtask

    always @(negedge clk) begin
        vec_t e, a;
        int l;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {state, mem_req, iord, mem_write, ir_write, pc_en, pc_src, alu_src_a, alu_src_b,
                 alu_control, reg_write, reg_dst, memto_reg, link, retire, halted};
            n_cmp++;
            if (a !== e) begin
                n_err++;
                $display("FAIL outputs t=%0t got %h expected %h", $time, a, e);
            end
        end
        if (reset) cyc_cnt = 0;
        else begin
            cyc_cnt++;
            if (retire === 1'b1) begin
                n_cmp++;
                if (lat_q.size() == 0) begin
                    n_err++;
                    $display("FAIL retire_unexpected t=%0t got retire expected none", $time);
                end else begin
                    l = lat_q.pop_front();
                    if (l != cyc_cnt) begin
                        n_err++;
                        $display("FAIL latency t=%0t got %0d expected %0d", $time, cyc_cnt, l);
                    end
                end
                cyc_cnt = 0;
            end
        end
    end

    initial begin
        ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J, OP_JAL};
        functs = '{F_ADD, F_SUB, F_AND, F_OR, F_SLT};
        @(posedge clk);
        #1;
        step(S_FETCH, 1'b1, 1'b1, 1'b0);
        run_instr(OP_R, F_ADD, 0, 0, 1'b0);
        run_instr(OP_LW, 6'h15, 0, 2, 1'b0);
        run_instr(OP_BEQ, 6'h00, 0, 0, 1'b1);
        run_instr(OP_BEQ, 6'h00, 1, 0, 1'b0);
        run_instr(OP_BNE, 6'h00, 0, 0, 1'b1);
        run_instr(OP_BNE, 6'h00, 0, 0, 1'b0);
        run_instr(OP_JAL, 6'h3f, 0, 0, 1'b0);
        halt_seq(6'b111111, F_ADD);
        halt_seq(OP_R, 6'b001000);
        op = OP_SW;
        funct = 6'h00;
        step(S_FETCH, 1'b1, 1'b0, rb());
        step(S_DECODE, rb(), 1'b0, rb());
        step(S_MEMADR, rb(), 1'b0, rb());
        step(S_MEMWRITE, 1'b0, 1'b0, rb());
        step(S_MEMWRITE, 1'b0, 1'b1, rb());
        step(S_FETCH, 1'b1, 1'b1, rb());
        for (int i = 0; i < 80; i++) begin
            o = ops[$urandom_range(7, 0)];
            run_instr(o, o == OP_R ? functs[$urandom_range(4, 0)] : 6'($urandom),
                      int'($urandom_range(2, 0)), int'($urandom_range(2, 0)), rb());
        end
        run_instr(OP_SW, 6'h00, 0, 0, 1'b0);
        repeat (2) @(posedge clk);
        n_cmp++;
        if (lat_q.size() != 0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain got %0d/%0d pending expected 0/0", lat_q.size(), exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
